// File: rtl/mips_mc_control_if.sv
// mips_mc_control_if: control bus; opcode/funct/zero_flag toward the controller, datapath strobes and debug state back out
interface mips_mc_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero_flag;
    logic [2:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       instr_done;
    logic       illegal_instr;
    logic [3:0] state;
    modport master (
        input  opcode, funct, zero_flag,
        output ALUControl, ALUSrcA, ALUSrcB, IorD, MemWrite, IRWrite, RegWrite,
               RegDst, MemtoReg, PCSrc, PCEn, instr_done, illegal_instr, state
    );
    modport slave (
        output opcode, funct, zero_flag,
        input  ALUControl, ALUSrcA, ALUSrcB, IorD, MemWrite, IRWrite, RegWrite,
               RegDst, MemtoReg, PCSrc, PCEn, instr_done, illegal_instr, state
    );
endinterface

// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS control FSM; clk, rst_n (sync, active low) and bus (opcode/funct/zero_flag in, ALU/mux selects, write strobes, PCEn, done/illegal pulses, state out)
module mips_mc_control (
    input  logic                  clk,
    input  logic                  rst_n,
    mips_mc_control_if.master     bus
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
        EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
    } state_t;
    state_t     r_state, w_next;
    logic [2:0] w_funct_alu;
    logic       w_funct_ok;
    logic       w_irwrite, w_memwrite, w_regwrite, w_pcwrite, w_branch, w_done, w_illegal;
    always_ff @(posedge clk)
        r_state <= !rst_n ? FETCH : w_next;
    always_comb begin
        w_funct_alu = 3'b010;
        w_funct_ok  = 1'b1;
        case (bus.funct)
            6'b100000: w_funct_alu = 3'b010;
            6'b100010: w_funct_alu = 3'b100;
            6'b100100: w_funct_alu = 3'b000;
            6'b100101: w_funct_alu = 3'b001;
            6'b101010: w_funct_alu = 3'b110;
            6'b011000: w_funct_alu = 3'b101;
            default:   w_funct_ok  = 1'b0;
        endcase
    end
    always_comb begin
        w_next         = FETCH;
        bus.ALUControl = 3'b000;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.IorD       = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.PCSrc      = 2'b00;
        w_irwrite      = 1'b0;
        w_memwrite     = 1'b0;
        w_regwrite     = 1'b0;
        w_pcwrite      = 1'b0;
        w_branch       = 1'b0;
        w_done         = 1'b0;
        w_illegal      = 1'b0;
        case (r_state)
            FETCH: begin
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = 3'b010;
                w_irwrite      = 1'b1;
                w_pcwrite      = 1'b1;
                w_next         = DECODE;
            end
            DECODE: begin
                bus.ALUSrcB    = 2'b11;
                bus.ALUControl = 3'b010;
                case (bus.opcode)
                    6'b100011, 6'b101011: w_next = MEMADR;
                    6'b000000: begin
                        w_next    = w_funct_ok ? EXEC : FETCH;
                        w_illegal = !w_funct_ok;
                    end
                    6'b000100: w_next = BRANCH;
                    6'b001000: w_next = ADDIEX;
                    6'b000010: w_next = JUMP;
                    default:   w_illegal = 1'b1;
                endcase
            end
            MEMADR, ADDIEX: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'b10;
                bus.ALUControl = 3'b010;
                w_next         = r_state == ADDIEX ? ADDIWB : bus.opcode == 6'b101011 ? MEMWR : MEMRD;
            end
            MEMRD: begin
                bus.IorD = 1'b1;
                w_next   = MEMWB;
            end
            MEMWB: begin
                bus.MemtoReg = 1'b1;
                w_regwrite   = 1'b1;
                w_done       = 1'b1;
            end
            MEMWR: begin
                bus.IorD   = 1'b1;
                w_memwrite = 1'b1;
                w_done     = 1'b1;
            end
            EXEC: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = w_funct_alu;
                w_next         = ALUWB;
            end
            ALUWB: begin
                bus.RegDst = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = 3'b100;
                bus.PCSrc      = 2'b01;
                w_branch       = 1'b1;
                w_done         = 1'b1;
            end
            ADDIWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            JUMP: begin
                bus.PCSrc = 2'b10;
                w_pcwrite = 1'b1;
                w_done    = 1'b1;
            end
            default: w_next = FETCH;
        endcase
    end
    // zero_flag only reaches PCEn through w_branch, so it is inert outside BRANCH
    assign bus.PCEn          = rst_n & (w_pcwrite | (w_branch & bus.zero_flag));
    assign bus.IRWrite       = rst_n & w_irwrite;
    assign bus.MemWrite      = rst_n & w_memwrite;
    assign bus.RegWrite      = rst_n & w_regwrite;
    assign bus.instr_done    = rst_n & w_done;
    assign bus.illegal_instr = rst_n & w_illegal;
    assign bus.state         = r_state;
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: randomized scoreboard bench for mips_mc_control against a per-instruction reference model
module tb_mips_mc_control;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    mips_mc_control_if bus();
    mips_mc_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int cyc; int fin; int ill; int rw; int mw; int pce; int alu; int rd; int m2r;
    } exp_t;
    exp_t q[$];
    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;
    int m_cyc, m_rw, m_mw, m_pce, m_alu, m_rd, m_m2r, m_irw;

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic int funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 2;
            6'b100010: return 4;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 6;
            6'b011000: return 5;
            default:   return -1;
        endcase
    endfunction

    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input int z);
        exp_t e;
        e = '{cyc: 2, fin: 1, ill: 1, rw: 0, mw: 0, pce: 0, alu: -1, rd: -1, m2r: -1};
        case (op)
            6'b100011: e = '{cyc: 5, fin: 4, ill: 0, rw: 1, mw: 0, pce: 0, alu: -1, rd: 0, m2r: 1};
            6'b101011: e = '{cyc: 4, fin: 5, ill: 0, rw: 0, mw: 1, pce: 0, alu: -1, rd: -1, m2r: -1};
            6'b000000: if (funct_alu(fn) >= 0)
                e = '{cyc: 4, fin: 7, ill: 0, rw: 1, mw: 0, pce: 0, alu: funct_alu(fn), rd: 1, m2r: 0};
            6'b000100: e = '{cyc: 3, fin: 8, ill: 0, rw: 0, mw: 0, pce: z, alu: -1, rd: -1, m2r: -1};
            6'b001000: e = '{cyc: 4, fin: 10, ill: 0, rw: 1, mw: 0, pce: 0, alu: -1, rd: 0, m2r: 0};
            6'b000010: e = '{cyc: 3, fin: 11, ill: 0, rw: 0, mw: 0, pce: 1, alu: -1, rd: -1, m2r: -1};
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                m_cyc = 0;
                chk("reset_strobes", int'({bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.PCEn,
                                           bus.instr_done, bus.illegal_instr}), 0);
            end else begin
                if (bus.state == 4'd0) begin
                    m_cyc = 0; m_rw = 0; m_mw = 0; m_pce = 0; m_irw = 0;
                    m_alu = -1; m_rd = -1; m_m2r = -1;
                    chk("fetch_irwrite", int'(bus.IRWrite), 1);
                    chk("fetch_pcen", int'(bus.PCEn), 1);
                    chk("fetch_alu", int'(bus.ALUControl), 2);
                end else begin
                    m_pce += int'(bus.PCEn);
                    m_irw += int'(bus.IRWrite);
                    if (bus.state == 4'd6) m_alu = int'(bus.ALUControl);
                end
                m_cyc++;
                m_mw += int'(bus.MemWrite);
                m_rw += int'(bus.RegWrite);
                if (bus.RegWrite) begin
                    m_rd = int'(bus.RegDst);
                    m_m2r = int'(bus.MemtoReg);
                end
                if (bus.instr_done || bus.illegal_instr) begin
                    if (q.size() == 0) chk("unexpected_output", 1, 0);
                    else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("cycles", m_cyc, e.cyc);
                        chk("final_state", int'(bus.state), e.fin);
                        chk("illegal", int'(bus.illegal_instr), e.ill);
                        chk("done", int'(bus.instr_done), 1 - e.ill);
                        chk("regwrite_cnt", m_rw, e.rw);
                        chk("memwrite_cnt", m_mw, e.mw);
                        chk("pcen_cnt", m_pce, e.pce);
                        chk("exec_alu", m_alu, e.alu);
                        chk("regdst", m_rd, e.rd);
                        chk("memtoreg", m_m2r, e.m2r);
                        chk("irwrite_extra", m_irw, 0);
                    end
                end
            end
        end
    end

    task automatic wait_fetch();
        int n = 0;
        while (bus.state != 4'd0 && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.state != 4'd0) chk("fetch_timeout", int'(bus.state), 0);
    endtask

    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input int z);
        exp_t e;
        wait_fetch();
        bus.opcode = op;
        bus.funct = fn;
        bus.zero_flag = 1'($urandom_range(0, 1));
        e = model(op, fn, z);
        q.push_back(e);
        for (int i = 1; i < e.cyc; i++) begin
            @(posedge clk); #1;
            bus.zero_flag = (op == 6'b000100 && i == 2) ? 1'(z) : 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [5:0] rand_illegal_op();
        logic [5:0] op;
        do op = 6'($urandom_range(0, 63));
        while (op inside {6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02});
        return op;
    endfunction

    function automatic logic [5:0] rand_bad_funct();
        logic [5:0] fn;
        do fn = 6'($urandom_range(0, 63));
        while (funct_alu(fn) >= 0);
        return fn;
    endfunction

    logic [5:0] fmap [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000};

    initial begin
        bus.opcode = 6'd0;
        bus.funct = 6'd0;
        bus.zero_flag = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", int'(bus.state), 0);
        chk("reset_strobes_init", int'({bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.PCEn,
                                        bus.instr_done, bus.illegal_instr}), 0);
        mon_en = 1'b1;
        rst_n = 1'b1;
        issue(6'b100011, 6'd0, 0);
        for (int i = 0; i < 6; i++) issue(6'b000000, fmap[i], 0);
        issue(6'b000100, 6'd0, 1);
        issue(6'b000100, 6'd0, 0);
        issue(6'b111111, 6'd0, 0);
        issue(6'b000000, 6'b000001, 0);
        issue(6'b101011, 6'd0, 0);
        issue(6'b001000, 6'd0, 0);
        issue(6'b000010, 6'd0, 0);
        wait_fetch();
        bus.opcode = 6'b101011;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midsw_memadr", int'(bus.state), 2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midsw_memwrite", int'(bus.MemWrite), 0);
        @(posedge clk); #1;
        chk("midsw_state", int'(bus.state), 0);
        rst_n = 1'b1;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 7))
                0: issue(6'b100011, 6'($urandom), 0);
                1: issue(6'b101011, 6'($urandom), 0);
                2: issue(6'b000000, fmap[$urandom_range(0, 5)], 0);
                3: issue(6'b001000, 6'($urandom), 0);
                4: issue(6'b000100, 6'($urandom), int'($urandom_range(0, 1)));
                5: issue(6'b000010, 6'($urandom), 0);
                6: issue(rand_illegal_op(), 6'($urandom), 0);
                default: issue(6'b000000, rand_bad_funct(), 0);
            endcase
        end
        wait_fetch();
        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
